// File: rtl/leg_pkg.sv
// Shared types for the EX/MEM stage: branch kinds, ARM condition codes, flag indices, payload.
package leg_pkg;

    typedef enum logic [1:0] {
        BrNone = 2'd0,
        BrCond = 2'd1,
        BrCbz  = 2'd2,
        BrCbnz = 2'd3
    } br_type_e;

    typedef enum logic [3:0] {
        CondEq, CondNe, CondHs, CondLo, CondMi, CondPl, CondVs, CondVc,
        CondHi, CondLs, CondGe, CondLt, CondGt, CondLe, CondAl, CondNv
    } cond_e;

    localparam int unsigned FlagN = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagC = 1;
    localparam int unsigned FlagV = 0;

    typedef struct packed {
        logic [63:0] alu;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [63:0] store_data;
        logic        br_taken;
        logic [63:0] br_target;
    } payload_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator against an NZCV flag nibble.
module cond_eval
    import leg_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       taken
);

    logic n, z, c, v;
    assign n = nzcv[FlagN];
    assign z = nzcv[FlagZ];
    assign c = nzcv[FlagC];
    assign v = nzcv[FlagV];

    always_comb begin
        taken = 1'b1;
        case (cond_e'(cond))
            CondEq:  taken = z;
            CondNe:  taken = !z;
            CondHs:  taken = c;
            CondLo:  taken = !c;
            CondMi:  taken = n;
            CondPl:  taken = !n;
            CondVs:  taken = v;
            CondVc:  taken = !v;
            CondHi:  taken = c && !z;
            CondLs:  taken = !c || z;
            CondGe:  taken = (n == v);
            CondLt:  taken = (n != v);
            CondGt:  taken = !z && (n == v);
            CondLe:  taken = z || (n != v);
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with NZCV flag register and branch resolution.
// Define EX_MEM_SKID_EN for a two-entry skid buffer with registered in_ready.
module ex_mem_stage
    import leg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] alu_out,
    input  logic [3:0]  alu_status,
    input  logic        set_flags,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [63:0] store_data,
    input  logic [1:0]  br_type,
    input  logic [3:0]  cond,
    input  logic [63:0] br_target,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_alu,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic [63:0] out_store_data,
    output logic        out_br_taken,
    output logic [63:0] out_br_target,
    output logic [3:0]  nzcv
);

    logic [3:0] nzcv_q;
    logic       cond_taken;
    logic       br_taken;
    logic       accept;
    payload_t   in_pl;
    payload_t   head;

    // B.cond sees the flags as they stand before this accept's own update
    cond_eval u_cond_eval (
        .cond  (cond),
        .nzcv  (nzcv_q),
        .taken (cond_taken)
    );

    always_comb begin
        br_taken = 1'b0;
        case (br_type_e'(br_type))
            BrCond:  br_taken = cond_taken;
            BrCbz:   br_taken = alu_status[FlagZ];
            BrCbnz:  br_taken = !alu_status[FlagZ];
            default: br_taken = 1'b0;
        endcase
    end

    assign in_pl = '{
        alu:        alu_out,
        rd:         rd,
        reg_write:  reg_write,
        mem_read:   mem_read,
        mem_write:  mem_write,
        store_data: store_data,
        br_taken:   br_taken,
        br_target:  br_target
    };

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv_q <= 4'b0000;
        end else if (accept && set_flags) begin
            nzcv_q <= alu_status;
        end
    end

    assign nzcv = nzcv_q;

`ifdef EX_MEM_SKID_EN
    payload_t   ent_q [2];
    payload_t   ent_d [2];
    logic [1:0] count_q, count_d;
    logic       in_ready_q;
    logic       pop;

    always_comb begin
        ent_d   = ent_q;
        count_d = count_q;
        pop     = (count_q != 2'd0) && out_ready;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                ent_d[0] = ent_q[1];
            end
            count_d = count_q - {1'b0, pop};
            // accept only happens with fewer than two held, so count_d is 0 or 1 here
            if (accept) begin
                ent_d[count_d[0]] = in_pl;
                count_d           = count_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q[0]   <= '0;
            ent_q[1]   <= '0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            ent_q      <= ent_d;
            count_q    <= count_d;
            in_ready_q <= (count_d != 2'd2);
        end
    end

    assign in_ready  = in_ready_q && !flush;
    assign out_valid = (count_q != 2'd0);
    assign head      = ent_q[0];
`else
    payload_t ent_q;
    logic     valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q   <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            ent_q   <= in_pl;
            valid_q <= 1'b1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign in_ready  = rst_n && !flush && (!valid_q || out_ready);
    assign out_valid = valid_q;
    assign head      = ent_q;
`endif

    assign out_alu        = head.alu;
    assign out_rd         = head.rd;
    assign out_reg_write  = head.reg_write;
    assign out_mem_read   = head.mem_read;
    assign out_mem_write  = head.mem_write;
    assign out_store_data = head.store_data;
    assign out_br_taken   = head.br_taken;
    assign out_br_target  = head.br_target;

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have inputs in_valid (1), alu_out (64), alu_status (4; [3]=N,[2]=Z,[1]=C,[0]=V), set_flags (1), rd (5), reg_write (1), mem_read (1), mem_write (1), store_data (64): executed-instruction payload from the ALU.
REQ-004 SHALL have inputs br_type (2; 0=none, 1=B.cond, 2=CBZ, 3=CBNZ), cond (4, ARM encoding), br_target (64).
REQ-005 SHALL have output in_ready (1): stage can accept this cycle.
REQ-006 SHALL have outputs out_valid (1) and registered copies out_alu, out_rd, out_reg_write, out_mem_read, out_mem_write, out_store_data, out_br_taken (1), out_br_target (64); input out_ready (1).
REQ-007 SHALL have input flush (1) and output nzcv (4): architectural flag register.

Function
REQ-008 SHALL accept on in_valid && in_ready and present the payload with out_valid=1 exactly one cycle later (latency 1).
REQ-009 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-010 SHALL, on accept with set_flags=1, load nzcv <= alu_status at that edge; otherwise nzcv holds.
REQ-011 SHALL compute out_br_taken at accept: B.cond evaluates cond against nzcv as held before that edge; CBZ taken iff alu_status[2]=1; CBNZ taken iff alu_status[2]=0; none gives 0.
REQ-012 SHALL evaluate cond as: EQ Z; NE !Z; HS C; LO !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL and NV always 1.
REQ-013 SHALL, on flush=1, invalidate all held entries at the next edge and not accept that cycle; nzcv is neither reverted nor updated.
REQ-014 SHALL, with simultaneous out_ready and accept while full, drain the held entry and load the new one in the same edge (no bubble).
REQ-015 SHALL drive in_ready=0 while flush=1.

Reset
REQ-016 SHALL, while rst_n=0, force out_valid=0, nzcv=4'b0000, out_br_taken=0, all other out_* to 0, in_ready=0; in_ready rises in the first cycle after deassertion; reset mid-transfer discards the entry.

Configuration
REQ-017 SHALL support macro EX_MEM_SKID_EN: defined -> two-entry skid buffer, in_ready is a registered signal (1 when fewer than 2 entries held), no combinational out_ready->in_ready path, entries leave in order.
REQ-018 SHALL, without EX_MEM_SKID_EN, use one entry with in_ready = !out_valid || out_ready (combinational).
REQ-019 SHALL apply REQ-010..REQ-013 identically in both builds; flag update happens at accept, not at drain.

Structure
REQ-020 SHALL place br_type enum, cond-code enum, flag-bit index constants and the payload struct in shared package leg_pkg.
REQ-021 SHALL implement condition evaluation as combinational sub-module cond_eval (inputs cond, nzcv; output taken).

Verification
REQ-022 Accept alu_out=5, alu_status=4'b0000, set_flags=1, then B.cond EQ -> nzcv=0000, second out_br_taken=0.
REQ-023 Accept SUBS with alu_status=4'b0110 then B.cond HI (8) -> nzcv=0110, out_br_taken=0; B.cond HS (2) -> out_br_taken=1.
REQ-024 CBZ with alu_out=0, alu_status=4'b0100 -> out_br_taken=1, nzcv unchanged; CBNZ same -> 0.
REQ-025 Hold out_ready=0 for 3 cycles while sending 3 items -> non-skid: one accepted, in_ready=0, outputs stable; skid: two accepted; release -> in-order drain, none lost.
REQ-026 Assert flush with one held entry and in_valid=1 set_flags=1 alu_status=4'b1000 -> out_valid=0 next cycle, nzcv unchanged.
REQ-027 Assert rst_n=0 mid-stall with out_valid=1 -> out_valid=0, nzcv=0000 immediately, no output after release.
